// File: rtl/armleocpu_mem_1rw_ctrl.sv
// Front-end controller for a single-port registered-read RAM: sweeps every entry
// to INIT_VALUE after reset or flush, otherwise serves one valid/ready client.
module armleocpu_mem_1rw_ctrl #(
    parameter int unsigned           ELEMENTS_W = 7,
    parameter int unsigned           WIDTH      = 32,
    parameter logic [WIDTH-1:0]      INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  flush,
    output logic                  busy,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ELEMENTS_W-1:0] req_address,
    input  logic [WIDTH-1:0]      req_writedata,

    output logic                  resp_valid,
    output logic [WIDTH-1:0]      resp_readdata,

    output logic [ELEMENTS_W-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WIDTH-1:0]      mem_writedata,
    input  logic [WIDTH-1:0]      mem_readdata
);

    typedef enum logic {
        SWEEP = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [ELEMENTS_W-1:0]   sweep_cnt, sweep_cnt_nxt;
    logic                    read_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SWEEP;
            sweep_cnt  <= '0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            sweep_cnt  <= sweep_cnt_nxt;
            resp_valid <= read_accept;
        end
    end

    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        busy          = 1'b0;
        req_ready     = 1'b0;
        mem_address   = req_address;
        mem_writedata = req_writedata;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        read_accept   = 1'b0;

        case (state)
            SWEEP: begin
                busy          = 1'b1;
                mem_write     = 1'b1;
                mem_address   = sweep_cnt;
                mem_writedata = INIT_VALUE;
                // flush wins even on the last entry, so the sweep always restarts cleanly
                if (flush) begin
                    sweep_cnt_nxt = '0;
                end else begin
                    sweep_cnt_nxt = sweep_cnt + 1'b1;
                    if (sweep_cnt == '1) begin
                        state_nxt = SERVE;
                    end
                end
            end
            SERVE: begin
                req_ready     = 1'b1;
                mem_write     = req_valid && req_write;
                mem_read      = req_valid && !req_write;
                read_accept   = req_valid && !req_write;
                sweep_cnt_nxt = '0;
                if (flush) begin
                    state_nxt = SWEEP;
                end
            end
            default: begin
                state_nxt     = SWEEP;
                sweep_cnt_nxt = '0;
            end
        endcase
    end

    // RAM already registers its output, so the response data is a pass-through
    assign resp_readdata = mem_readdata;

endmodule
